// File: rtl/onehot_line_encoder.sv
// One-hot line word -> 3-bit index encoder behind a 2-entry valid/ready FIFO,
// with a saturating count of non-one-hot words. Option: ONEHOT_ENC_DROP_ERR_EN.
module onehot_line_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [7:0]       F,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [2:0]       Code,
  output logic             Error,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [CNT_W-1:0] Err_Count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic       err;
    logic [2:0] code;
  } entry_t;

  state_t           state_q;
  entry_t           head_q, tail_q, enc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop, store;

  // F[7] has priority: scanning upward, the highest set bit overwrites last.
  always_comb begin
    enc_d.code = 3'd0;
    for (int k = 0; k < 8; k++)
      if (F[k]) enc_d.code = 3'(7 - k);
    enc_d.err = (F == 8'd0) || ((F & (F - 8'd1)) != 8'd0);
  end

  assign In_Ready  = (state_q != FULL);
  assign Out_Valid = (state_q != EMPTY);
  assign push      = In_Valid && In_Ready;
  assign pop       = Out_Valid && Out_Ready;

`ifdef ONEHOT_ENC_DROP_ERR_EN
  // Errored words are counted but never enter the FIFO, so stored err is always 0.
  assign store = push && !enc_d.err;
`else
  assign store = push;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (push && enc_d.err && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        EMPTY: begin
          if (store) begin
            head_q  <= enc_d;
            state_q <= ONE;
          end
        end
        ONE: begin
          case ({store, pop})
            2'b10: begin
              tail_q  <= enc_d;
              state_q <= FULL;
            end
            2'b01: state_q <= EMPTY;
            2'b11: head_q  <= enc_d;
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head_q  <= tail_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign Code      = head_q.code;
  assign Error     = head_q.err;
  assign Err_Count = cnt_q;

endmodule

// File: tb/tb_onehot_line_encoder.sv
// Directed-vector bench for onehot_line_encoder; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_onehot_line_encoder;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] F;
  logic       In_Valid, Out_Ready;
  logic       In_Ready, Error, Out_Valid;
  logic [2:0] Code;
  logic [7:0] Err_Count;
  logic       In_Ready2, Error2, Out_Valid2;
  logic [2:0] Code2;
  logic [1:0] Err_Count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  onehot_line_encoder #(.CNT_W(8)) u_dut (
    .Clock(Clock), .Reset(Reset), .F(F), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Code(Code), .Error(Error), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Err_Count(Err_Count)
  );

  onehot_line_encoder #(.CNT_W(2)) u_dut2 (
    .Clock(Clock), .Reset(Reset), .F(F), .In_Valid(In_Valid), .In_Ready(In_Ready2),
    .Code(Code2), .Error(Error2), .Out_Valid(Out_Valid2), .Out_Ready(Out_Ready),
    .Err_Count(Err_Count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0; F = 8'd0;
    #3;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0; F = 8'd0;
    #12;
    chk("rst_in_ready", In_Ready, 1);
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_code", Code, 0);
    chk("rst_error", Error, 0);
    chk("rst_cnt", Err_Count, 0);
    Reset = 1'b0;

    // basic one-cycle latency, then drain
    In_Valid = 1'b1; F = 8'b0010_0000; Out_Ready = 1'b1;
    cyc();
    In_Valid = 1'b0;
    chk("lat_valid", Out_Valid, 1);
    chk("lat_code", Code, 2);
    chk("lat_error", Error, 0);
    cyc();
    chk("lat_drain", Out_Valid, 0);

    // fill to FULL, check ordering and head stability
    Out_Ready = 1'b0; In_Valid = 1'b1; F = 8'b1000_0000;
    cyc();
    chk("one_code", Code, 0);
    F = 8'b0000_0001;
    cyc();
    chk("full_in_ready", In_Ready, 0);
    chk("full_out_valid", Out_Valid, 1);
    In_Valid = 1'b0; F = 8'hFF;
    cyc();
    chk("full_hold_code", Code, 0);
    chk("full_hold_err", Error, 0);
    Out_Ready = 1'b1;
    cyc();
    chk("pop1_code", Code, 7);
    chk("pop1_valid", Out_Valid, 1);
    chk("pop1_in_ready", In_Ready, 1);
    cyc();
    chk("pop2_valid", Out_Valid, 0);

    // error words: zero and multi-hot
    Out_Ready = 1'b0; In_Valid = 1'b1; F = 8'd0;
    cyc();
    F = 8'b0100_0100;
    cyc();
`ifdef ONEHOT_ENC_DROP_ERR_EN
    In_Valid = 1'b0;
    chk("drop_valid", Out_Valid, 0);
    chk("drop_cnt", Err_Count, 2);
    chk("drop_error", Error, 0);
`else
    // In_Valid stays high with FULL: no push, counter must not move
    F = 8'd0;
    cyc();
    In_Valid = 1'b0;
    chk("err_cnt_full", Err_Count, 2);
    chk("err0_code", Code, 0);
    chk("err0_error", Error, 1);
    Out_Ready = 1'b1;
    cyc();
    chk("err1_code", Code, 1);
    chk("err1_error", Error, 1);
    cyc();
    chk("err_drain", Out_Valid, 0);
`endif

    // saturation on CNT_W=2 instance
    do_reset();
    Out_Ready = 1'b1; In_Valid = 1'b1; F = 8'b1100_0000;
    cyc(); chk("sat_1", Err_Count2, 1);
    cyc(); chk("sat_2", Err_Count2, 2);
    cyc(); chk("sat_3", Err_Count2, 3);
    cyc(); chk("sat_4", Err_Count2, 3);
    cyc(); chk("sat_5", Err_Count2, 3);
    chk("cnt8_5", Err_Count, 5);
`ifndef ONEHOT_ENC_DROP_ERR_EN
    chk("sat_code", Code, 0);
    chk("sat_error", Error, 1);
`endif

    // streaming in ONE with simultaneous push and pop
    do_reset();
    In_Valid = 1'b1; F = 8'b0001_0000; Out_Ready = 1'b0;
    cyc();
    Out_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("stream_valid", Out_Valid, 1);
      chk("stream_code", Code, 3);
      chk("stream_in_ready", In_Ready, 1);
    end

    // asynchronous reset mid-operation
    do_reset();
    In_Valid = 1'b1; F = 8'b0000_1000;
    cyc();
    F = 8'd0;
    cyc();
    In_Valid = 1'b0;
    chk("pre_rst_cnt", Err_Count, 1);
`ifndef ONEHOT_ENC_DROP_ERR_EN
    chk("pre_rst_full", In_Ready, 0);
`endif
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_out_valid", Out_Valid, 0);
    chk("arst_in_ready", In_Ready, 1);
    chk("arst_cnt", Err_Count, 0);
    chk("arst_code", Code, 0);
    #1;
    Reset = 1'b0;
    In_Valid = 1'b1; F = 8'b0000_0010;
    cyc();
    In_Valid = 1'b0;
    chk("post_rst_valid", Out_Valid, 1);
    chk("post_rst_code", Code, 6);
    chk("post_rst_error", Error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
